// File: rtl/present_pkg.sv
`default_nettype none
// ============================================================================
//  present_pkg
//  Shared types, widths and S-box helper for the PRESENT-80 key schedule.
//  Revision: 1.0
// ============================================================================
package present_pkg;

  localparam int KEY_W      = 80;
  localparam int RK_W       = 64;
  localparam int NUM_ROUNDS = 31;

  typedef logic [KEY_W-1:0] key_t;
  typedef logic [RK_W-1:0]  round_key_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } ks_state_t;

  // PRESENT 4-bit S-box
  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_update.sv
`default_nettype none
// ============================================================================
//  key_update
//  One PRESENT-80 key-register update: rotate left by 61, S-box the top
//  nibble, XOR the round counter into bits [19:15]. Purely combinational.
//  Revision: 1.0
// ============================================================================
module key_update
  import present_pkg::*;
(
  input  key_t       data_i,
  input  logic [4:0] round_counter,
  output key_t       data_o
);

  key_t rot;

  // rotate, substitute, then mix in the round counter
  always_comb begin
    rot             = {data_i[18:0], data_i[79:19]};
    data_o          = rot;
    data_o[79:76]   = sbox4(rot[79:76]);
    data_o[19:15]   = rot[19:15] ^ round_counter;
  end

endmodule
`default_nettype wire

// File: rtl/present_key_schedule.sv
`default_nettype none
// ============================================================================
//  present_key_schedule
//  Holds the 80-bit key register and steps it one round per advance,
//  presenting round keys K1..K(NUM_ROUNDS+1) to the round datapath.
//  Revision: 1.0
// ============================================================================
module present_key_schedule #(
  parameter int NUM_ROUNDS = present_pkg::NUM_ROUNDS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     key_load_i,
  input  logic [present_pkg::KEY_W-1:0] key_i,
  input  logic                     next_i,
  output logic [present_pkg::RK_W-1:0]  round_key_o,
  output logic                     rk_valid_o,
  output logic [5:0]               key_idx_o,
  output logic                     last_o,
  output logic                     done_o
);

  import present_pkg::*;

  ks_state_t state;
  ks_state_t state_nxt;
  key_t      key_reg;
  key_t      key_next;
  logic [5:0] key_idx;
  logic      done_r;

  // The counter handed to key_update is the index of the key being replaced.
  key_update u_key_update (
    .data_i        (key_reg),
    .round_counter (key_idx[4:0]),
    .data_o        (key_next)
  );

  // Next-state decode; a load always restarts the schedule.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (key_load_i) state_nxt = RUN;
      RUN: begin
        if (key_load_i)                                state_nxt = RUN;
        else if (next_i && key_idx == 6'(NUM_ROUNDS))  state_nxt = LAST;
      end
      LAST: begin
        if (key_load_i)  state_nxt = RUN;
        else if (next_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, key register, index and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      key_reg <= '0;
      key_idx <= '0;
      done_r  <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_r <= (state == LAST) && next_i && !key_load_i;
      if (key_load_i) begin
        key_reg <= key_i;
        key_idx <= 6'd1;
      end else begin
        case (state)
          RUN: if (next_i) begin
            key_reg <= key_next;
            key_idx <= key_idx + 6'd1;
          end
          // the final key stays in key_reg; no update after the last key
          LAST: if (next_i) key_idx <= 6'd0;
          default: ;
        endcase
      end
    end
  end

  // Output decode from registered state.
  always_comb begin
    round_key_o = key_reg[79:16];
    rk_valid_o  = (state != IDLE);
    last_o      = (state == LAST);
    key_idx_o   = key_idx;
    done_o      = done_r;
  end

endmodule
`default_nettype wire

// File: tb/tb_present_key_schedule.sv
`default_nettype none
// ============================================================================
//  tb_present_key_schedule
//  Self-checking bench: behavioural schedule model + per-cycle compare,
//  plus literal expectations for known PRESENT-80 vectors.
//  Revision: 1.0
// ============================================================================
module tb_present_key_schedule;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_load = 1'b0;
  logic [79:0] key = '0;
  logic        next = 1'b0;
  logic [63:0] round_key;
  logic        rk_valid;
  logic [5:0]  key_idx;
  logic        last;
  logic        done;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int k1_cyc   = 0;
  int done_cyc = 0;

  logic [63:0] dut_keys [33];

  // model state
  int          m_idx  = 0;
  logic [79:0] m_key0 = '0;
  logic        m_done = 1'b0;

  present_key_schedule dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_load_i  (key_load),
    .key_i       (key),
    .next_i      (next),
    .round_key_o (round_key),
    .rk_valid_o  (rk_valid),
    .key_idx_o   (key_idx),
    .last_o      (last),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [3:0] sb(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h21748FE3DA09B65C; // nibble n holds S(n)
    return tbl[x*4 +: 4];
  endfunction

  // one key-register update as stated by the PRESENT-80 algorithm
  function automatic logic [79:0] ks_step(input logic [79:0] k, input int rc);
    logic [79:0] r;
    r = (k << 61) | (k >> 19);
    r[79:76] = sb(r[79:76]);
    r[19:15] = r[19:15] ^ rc[4:0];
    return r;
  endfunction

  // round key K(idx) for a given user key
  function automatic logic [63:0] rk_of(input logic [79:0] k0, input int idx);
    logic [79:0] k;
    k = k0;
    for (int i = 1; i < idx; i++) k = ks_step(k, i);
    return k[79:16];
  endfunction

  // full PRESENT-80 encryption given round keys 1..32
  function automatic logic [63:0] enc(input logic [63:0] pt, input logic [63:0] rk [33]);
    logic [63:0] s, t, p;
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ rk[r];
      for (int n = 0; n < 16; n++) t[n*4 +: 4] = sb(s[n*4 +: 4]);
      p = '0;
      for (int i = 0; i < 64; i++) p[(i == 63) ? 63 : (i * 16) % 63] = t[i];
      s = p;
    end
    return s ^ rk[32];
  endfunction

  // behavioural model: index walks 1..32 then back to idle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idx  <= 0;
      m_key0 <= '0;
      m_done <= 1'b0;
    end else if (key_load) begin
      m_idx  <= 1;
      m_key0 <= key;
      m_done <= 1'b0;
    end else if (m_idx != 0 && next) begin
      m_idx  <= (m_idx == 32) ? 0 : m_idx + 1;
      m_done <= (m_idx == 32);
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // compare DUT against the model on every falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 80'(rk_valid), 80'(0));
      chk("rst_idx",   80'(key_idx),  80'(0));
      chk("rst_rk",    80'(round_key), 80'(0));
      chk("rst_done",  80'(done),     80'(0));
    end else begin
      chk("valid", 80'(rk_valid), 80'(m_idx != 0));
      chk("idx",   80'(key_idx),  80'(m_idx));
      chk("last",  80'(last),     80'(m_idx == 32));
      chk("done",  80'(done),     80'(m_done));
      if (m_idx != 0) chk("round_key", 80'(round_key), 80'(rk_of(m_key0, m_idx)));
      if (rk_valid && key_idx <= 6'd32) dut_keys[key_idx] = round_key;
      if (rk_valid && key_idx == 6'd1) k1_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [79:0] k, input logic nx);
    key_load = 1'b1;
    key      = k;
    next     = nx;
    tick();
    key_load = 1'b0;
  endtask

  initial begin
    logic [63:0] mk [33];
    int snap;
    for (int i = 0; i < 33; i++) dut_keys[i] = '0;

    // model pins: known zero-key schedule and ciphertext
    chk("model_k2_zero", 80'(rk_of(80'h0, 2)), 80'(64'hC000_0000_0000_0000));
    chk("model_k2_ones", 80'(rk_of({80{1'b1}}, 2)), 80'(64'h2FFF_FFFF_FFFF_FFFF));
    mk[0] = '0;
    for (int i = 1; i <= 32; i++) mk[i] = rk_of(80'h0, i);
    chk("model_cipher", 80'(enc(64'h0, mk)), 80'(64'h5579_C138_7B22_8445));

    // reset
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // zero key, single step
    load(80'h0, 1'b0);
    @(negedge clk);
    chk("zero_k1", 80'(round_key), 80'(64'h0));
    chk("zero_idx1", 80'(key_idx), 80'(1));
    #1; next = 1'b1; tick(); next = 1'b0;
    @(negedge clk);
    chk("zero_k2", 80'(round_key), 80'(64'hC000_0000_0000_0000));

    // all-ones key, single step
    #1; load({80{1'b1}}, 1'b0);
    @(negedge clk);
    chk("ones_k1", 80'(round_key), 80'(64'hFFFF_FFFF_FFFF_FFFF));
    #1; next = 1'b1; tick(); next = 1'b0;
    @(negedge clk);
    chk("ones_k2", 80'(round_key), 80'(64'h2FFF_FFFF_FFFF_FFFF));

    // full back-to-back run on the zero key
    #1; snap = done_cnt;
    load(80'h0, 1'b1);
    repeat (34) tick();
    next = 1'b0;
    chk("full_done_once", 80'(done_cnt - snap), 80'(1));
    chk("full_latency", 80'(done_cyc - k1_cyc), 80'(32));
    chk("full_cipher", 80'(enc(64'h0, dut_keys)), 80'(64'h5579_C138_7B22_8445));

    // stalls with random gaps
    snap = done_cnt;
    load(80'h0123_4567_89AB_CDEF_0123, 1'b0);
    for (int c = 0; c < 300 && done_cnt == snap; c++) begin
      next = 1'($urandom_range(0, 1));
      tick();
    end
    next = 1'b0;
    chk("stall_done_once", 80'(done_cnt - snap), 80'(1));
    tick();

    // reload at key_idx 17 with next asserted
    snap = done_cnt;
    load(80'hDEAD_BEEF_0000_1111_2222, 1'b1);
    repeat (16) tick();
    @(negedge clk);
    chk("reload_pre_idx", 80'(key_idx), 80'(17));
    #1; load(80'h1357_9BDF_2468_ACE0_FFFF, 1'b1);
    @(negedge clk);
    chk("reload_idx", 80'(key_idx), 80'(1));
    chk("reload_k1", 80'(round_key), 80'(64'h1357_9BDF_2468_ACE0));
    #1; repeat (5) tick();
    next = 1'b0;
    chk("reload_no_done", 80'(done_cnt - snap), 80'(0));

    // asynchronous reset mid-cycle at key_idx 9
    load(80'hA5A5_5A5A_F0F0_0F0F_1234, 1'b1);
    repeat (8) tick();
    @(negedge clk);
    chk("areset_pre_idx", 80'(key_idx), 80'(9));
    #2; rst_n = 1'b0;
    #1;
    chk("areset_valid", 80'(rk_valid), 80'(0));
    chk("areset_idx", 80'(key_idx), 80'(0));
    chk("areset_rk", 80'(round_key), 80'(0));
    chk("areset_last", 80'(last), 80'(0));
    chk("areset_done", 80'(done), 80'(0));
    tick(); tick();
    rst_n = 1'b1;
    next  = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("post_reset_idle", 80'(rk_valid), 80'(0));
    #1; load(80'h0, 1'b1);
    repeat (4) tick();
    next = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
